// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-requester arbiter and sequencer for the SPRAM-backed 32-bit data memory.
// Port A (CPU load/store) and port B (UART debug/loader) share one SPRAM pair.
// At most one access is granted per cycle, with round-robin fairness on ties.
// The granted byte address and byte enables become an SPRAM word address and
// a nibble write mask. The response comes back on the granting port exactly
// one cycle later. Misaligned or out-of-range accesses are granted and
// acknowledged with err = 1, but they never touch the memory.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   a_* / b_*               requester ports: req/we/addr/wdata/be in,
//                           gnt (combinational), rvalid/rdata/err out
//   mem_addr                SPRAM word address (ADDR_WIDTH bits)
//   mem_wdata               SPRAM write data ([31:16] MSW bank, [15:0] LSW bank)
//   mem_maskwren            nibble write mask ([7:4] MSW bank, [3:0] LSW bank)
//   mem_wren, mem_cs        SPRAM write enable and chip select
//   mem_rdata               SPRAM read data, one cycle after a read
module dmem_arbiter #(
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [31:0]           a_addr,
   input  logic [31:0]           a_wdata,
   input  logic [3:0]            a_be,
   output logic                  a_gnt,
   output logic                  a_rvalid,
   output logic [31:0]           a_rdata,
   output logic                  a_err,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [31:0]           b_addr,
   input  logic [31:0]           b_wdata,
   input  logic [3:0]            b_be,
   output logic                  b_gnt,
   output logic                  b_rvalid,
   output logic [31:0]           b_rdata,
   output logic                  b_err,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic [7:0]            mem_maskwren,
   output logic                  mem_wren,
   output logic                  mem_cs,
   input  logic [31:0]           mem_rdata
);

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_e;

   // Each byte enable covers two SPRAM nibbles.
   function automatic logic [7:0] expand_be(input logic [3:0] be);
      logic [7:0] mask;
      mask = 8'h00;
      for (int k = 0; k < 4; k++) begin
         mask[2*k +: 2] = {2{be[k]}};
      end
      return mask;
   endfunction

   // Misaligned, or any address bit above the SPRAM word range is set.
   function automatic logic addr_err(input logic [31:0] addr);
      return (addr[1:0] != 2'b00) || (|addr[31:ADDR_WIDTH+2]);
   endfunction

   port_e       last_q, last_d;
   logic        resp_valid_q, resp_valid_d;
   port_e       resp_port_q, resp_port_d;
   logic        resp_read_q, resp_read_d;
   logic        resp_err_q, resp_err_d;

   logic        a_win_s, b_win_s, gnt_s;
   logic        sel_we_s, sel_err_s, rdata_ok_s;
   logic [31:0] sel_addr_s, sel_wdata_s;
   logic [3:0]  sel_be_s;

   // Winner selection: lone requester wins, a tie goes to the port not granted last.
   always_comb begin
      a_win_s = 1'b0;
      b_win_s = 1'b0;
      if (reset) begin
         a_win_s = 1'b0;
         b_win_s = 1'b0;
      end else if (a_req && b_req) begin
         if (last_q == PORT_B) begin
            a_win_s = 1'b1;
         end else begin
            b_win_s = 1'b1;
         end
      end else if (a_req) begin
         a_win_s = 1'b1;
      end else if (b_req) begin
         b_win_s = 1'b1;
      end else begin
         a_win_s = 1'b0;
         b_win_s = 1'b0;
      end
   end

   assign gnt_s = a_win_s | b_win_s;
   assign a_gnt = a_win_s;
   assign b_gnt = b_win_s;

   // Route the winning port's request fields; all zero when nobody is granted.
   always_comb begin
      sel_we_s    = 1'b0;
      sel_addr_s  = 32'h0000_0000;
      sel_wdata_s = 32'h0000_0000;
      sel_be_s    = 4'h0;
      if (a_win_s) begin
         sel_we_s    = a_we;
         sel_addr_s  = a_addr;
         sel_wdata_s = a_wdata;
         sel_be_s    = a_be;
      end else if (b_win_s) begin
         sel_we_s    = b_we;
         sel_addr_s  = b_addr;
         sel_wdata_s = b_wdata;
         sel_be_s    = b_be;
      end else begin
         sel_we_s    = 1'b0;
         sel_addr_s  = 32'h0000_0000;
      end
   end

   assign sel_err_s = gnt_s & addr_err(sel_addr_s);

   // SPRAM drive: an erroring grant keeps cs/wren low so memory is untouched.
   always_comb begin
      mem_cs       = 1'b0;
      mem_wren     = 1'b0;
      mem_addr     = {ADDR_WIDTH{1'b0}};
      mem_wdata    = 32'h0000_0000;
      mem_maskwren = 8'h00;
      if (gnt_s) begin
         mem_addr  = sel_addr_s[ADDR_WIDTH+1:2];
         mem_wdata = sel_wdata_s;
         if (!sel_err_s) begin
            mem_cs = 1'b1;
            if (sel_we_s) begin
               mem_wren     = 1'b1;
               mem_maskwren = expand_be(sel_be_s);
            end else begin
               mem_wren     = 1'b0;
               mem_maskwren = 8'hFF;
            end
         end else begin
            mem_cs = 1'b0;
         end
      end else begin
         mem_addr = {ADDR_WIDTH{1'b0}};
      end
   end

   // Next state: round-robin pointer and the response captured at grant.
   always_comb begin
      last_d       = last_q;
      resp_valid_d = gnt_s;
      resp_port_d  = resp_port_q;
      resp_read_d  = 1'b0;
      resp_err_d   = 1'b0;
      if (gnt_s) begin
         if (b_win_s) begin
            last_d      = PORT_B;
            resp_port_d = PORT_B;
         end else begin
            last_d      = PORT_A;
            resp_port_d = PORT_A;
         end
         resp_read_d = ~sel_we_s;
         resp_err_d  = sel_err_s;
      end else begin
         resp_read_d = 1'b0;
         resp_err_d  = 1'b0;
      end
   end

   // State registers; reset leaves B as last so A wins the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_q       <= PORT_B;
         resp_valid_q <= 1'b0;
         resp_port_q  <= PORT_A;
         resp_read_q  <= 1'b0;
         resp_err_q   <= 1'b0;
      end else begin
         last_q       <= last_d;
         resp_valid_q <= resp_valid_d;
         resp_port_q  <= resp_port_d;
         resp_read_q  <= resp_read_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Reset also masks a response that was captured just before it rose.
   assign rdata_ok_s = resp_read_q & ~resp_err_q;
   assign a_rvalid   = resp_valid_q & (resp_port_q == PORT_A) & ~reset;
   assign b_rvalid   = resp_valid_q & (resp_port_q == PORT_B) & ~reset;
   assign a_err      = a_rvalid & resp_err_q;
   assign b_err      = b_rvalid & resp_err_q;
   assign a_rdata    = (a_rvalid && rdata_ok_s) ? mem_rdata : 32'h0000_0000;
   assign b_rdata    = (b_rvalid && rdata_ok_s) ? mem_rdata : 32'h0000_0000;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a behavioural SPRAM answers the DUT,
// a reference model predicts each cycle's grant and response, and the
// expected responses are queued and compared one cycle later.
module tb_dmem_arbiter;

   localparam int AW = 14;

   typedef struct packed {
      logic        valid;
      logic        port;   // 0 = A, 1 = B
      logic        err;
      logic [31:0] rdata;
   } resp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          a_req, a_we, b_req, b_we;
   logic [31:0]   a_addr, a_wdata, b_addr, b_wdata;
   logic [3:0]    a_be, b_be;
   logic          a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
   logic [31:0]   a_rdata, b_rdata;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [7:0]    mem_maskwren;
   logic          mem_wren, mem_cs;
   logic [31:0]   mem_rdata = 32'h0;

   bit [31:0] spram   [0:(1<<AW)-1];
   bit [31:0] ref_mem [0:(1<<AW)-1];
   resp_t     exp_q[$];
   logic      last_m;   // 1 = B granted most recently
   int        checks = 0;
   int        failures = 0;

   dmem_arbiter #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_maskwren(mem_maskwren),
      .mem_wren(mem_wren), .mem_cs(mem_cs), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural SPRAM pair: nibble-masked writes, registered reads.
   always @(posedge clk) begin
      if (mem_cs) begin
         if (mem_wren) begin
            for (int n = 0; n < 8; n++) begin
               if (mem_maskwren[n]) spram[mem_addr][4*n +: 4] <= mem_wdata[4*n +: 4];
            end
         end else begin
            mem_rdata <= spram[mem_addr];
         end
      end
   end

   task automatic drive_a(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
      a_req = req; a_we = we; a_addr = addr; a_wdata = wdata; a_be = be;
   endtask

   task automatic drive_b(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
      b_req = req; b_we = we; b_addr = addr; b_wdata = wdata; b_be = be;
   endtask

   task automatic drive_idle();
      drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive_b(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
   endtask

   // Reference model: predicts this cycle's grant and queues the response.
   task automatic predict(output logic ga, output logic gb);
      resp_t       r;
      logic [31:0] ad, wd;
      logic        we;
      logic [3:0]  be;
      int          w;
      ga = 1'b0; gb = 1'b0;
      if (!reset) begin
         if (a_req && b_req) begin
            ga = last_m; gb = ~last_m;
         end else begin
            ga = a_req; gb = b_req;
         end
      end
      r.valid = ga | gb; r.port = gb; r.err = 1'b0; r.rdata = 32'h0;
      if (gb) begin ad = b_addr; we = b_we; wd = b_wdata; be = b_be; end
      else    begin ad = a_addr; we = a_we; wd = a_wdata; be = a_be; end
      if (r.valid) begin
         last_m = gb;
         r.err = (ad[1:0] != 2'b00) || ((ad >> (AW + 2)) != 32'd0);
         if (!r.err) begin
            w = int'(ad[AW+1:2]);
            if (we) begin
               for (int k = 0; k < 4; k++) begin
                  if (be[k]) ref_mem[w][8*k +: 8] = wd[8*k +: 8];
               end
            end else begin
               r.rdata = ref_mem[w];
            end
         end
      end
      exp_q.push_back(r);
   endtask

   task automatic do_reset();
      reset = 1'b1; drive_idle(); last_m = 1'b1; exp_q.delete();
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; last_m = 1'b1; exp_q.delete();
      drive_a(1'b1, 1'b0, 32'h14, 32'h0, 4'hF);
      drive_b(1'b1, 1'b1, 32'h20, 32'h5, 4'hF);
      repeat (2) begin @(posedge clk); #1; end
      #2;
      checks++; if ({a_gnt, b_gnt} !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", {a_gnt, b_gnt}); end
      checks++; if ({mem_cs, mem_wren} !== 2'b00) begin failures++; $display("FAIL reset_mem got cs/wren=%b exp=00", {mem_cs, mem_wren}); end
      checks++; if ({a_rvalid, b_rvalid, a_err, b_err} !== 4'b0000) begin failures++; $display("FAIL reset_resp got=%b exp=0000", {a_rvalid, b_rvalid, a_err, b_err}); end
      checks++; if ((a_rdata | b_rdata) !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", a_rdata | b_rdata); end
      @(posedge clk); #1;
      reset = 1'b0; drive_idle();
      #2;
      checks++; if ({a_rvalid, b_rvalid} !== 2'b00) begin failures++; $display("FAIL post_reset_rvalid got=%b exp=00", {a_rvalid, b_rvalid}); end
      @(posedge clk); #1;
      checks++; if ({a_rvalid, b_rvalid} !== 2'b00) begin failures++; $display("FAIL idle_rvalid got=%b exp=00", {a_rvalid, b_rvalid}); end
   endtask

   task automatic test_single_read();
      logic ga, gb; resp_t r; logic [32:0] got;
      for (int c = 0; c < 2; c++) begin
         drive_idle();
         if (c == 0) drive_b(1'b1, 1'b1, 32'h14, 32'hDEADBEEF, 4'hF);
         else        drive_a(1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
         predict(ga, gb);
         #2;
         checks++; if ({a_gnt, b_gnt} !== {ga, gb}) begin failures++; $display("FAIL rd_gnt c=%0d got=%b exp=%b", c, {a_gnt, b_gnt}, {ga, gb}); end
         if (c == 1) begin
            checks++;
            if ({mem_addr, mem_cs, mem_wren, mem_maskwren} !== {14'd5, 1'b1, 1'b0, 8'hFF}) begin
               failures++; $display("FAIL rd_mem got addr=%0d cs=%b wren=%b mask=%h exp addr=5 cs=1 wren=0 mask=ff", mem_addr, mem_cs, mem_wren, mem_maskwren);
            end
         end
         @(posedge clk); #1;
         if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL rd_sb_empty got=0 entries exp=1"); end
         else begin
            r = exp_q.pop_front();
            checks++; if ({a_rvalid, b_rvalid} !== {r.valid & ~r.port, r.valid & r.port}) begin failures++; $display("FAIL rd_rvalid c=%0d got=%b exp=%b", c, {a_rvalid, b_rvalid}, {r.valid & ~r.port, r.valid & r.port}); end
            if (r.valid) begin
               checks++; got = r.port ? {b_err, b_rdata} : {a_err, a_rdata};
               if (got !== {r.err, r.rdata}) begin failures++; $display("FAIL rd_resp c=%0d got err=%b data=%h exp err=%b data=%h", c, got[32], got[31:0], r.err, r.rdata); end
            end
         end
      end
   endtask

   task automatic test_masked_write();
      logic ga, gb; resp_t r; logic [32:0] got;
      for (int c = 0; c < 3; c++) begin
         drive_idle();
         case (c)
            0:       drive_b(1'b1, 1'b1, 32'h20, 32'h0, 4'hF);
            1:       drive_b(1'b1, 1'b1, 32'h20, 32'h11223344, 4'b0101);
            default: drive_b(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
         endcase
         predict(ga, gb);
         #2;
         checks++; if ({a_gnt, b_gnt} !== {ga, gb}) begin failures++; $display("FAIL wr_gnt c=%0d got=%b exp=%b", c, {a_gnt, b_gnt}, {ga, gb}); end
         if (c == 1) begin
            checks++;
            if ({mem_addr, mem_cs, mem_wren, mem_maskwren, mem_wdata} !== {14'd8, 1'b1, 1'b1, 8'b0011_0011, 32'h11223344}) begin
               failures++; $display("FAIL wr_mem got addr=%0d cs=%b wren=%b mask=%b wdata=%h exp addr=8 cs=1 wren=1 mask=00110011 wdata=11223344", mem_addr, mem_cs, mem_wren, mem_maskwren, mem_wdata);
            end
         end
         @(posedge clk); #1;
         if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL wr_sb_empty got=0 entries exp=1"); end
         else begin
            r = exp_q.pop_front();
            if (c == 2) begin
               checks++; if (b_rdata !== 32'h00220044) begin failures++; $display("FAIL wr_readback got=%h exp=00220044", b_rdata); end
            end
            checks++; if ({a_rvalid, b_rvalid} !== {r.valid & ~r.port, r.valid & r.port}) begin failures++; $display("FAIL wr_rvalid c=%0d got=%b exp=%b", c, {a_rvalid, b_rvalid}, {r.valid & ~r.port, r.valid & r.port}); end
            if (r.valid) begin
               checks++; got = r.port ? {b_err, b_rdata} : {a_err, a_rdata};
               if (got !== {r.err, r.rdata}) begin failures++; $display("FAIL wr_resp c=%0d got err=%b data=%h exp err=%b data=%h", c, got[32], got[31:0], r.err, r.rdata); end
            end
         end
      end
   endtask

   task automatic test_tie_alternation();
      logic ga, gb; resp_t r; logic [32:0] got;
      do_reset();
      for (int c = 0; c < 4; c++) begin
         drive_a(1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
         drive_b(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
         predict(ga, gb);
         #2;
         checks++;
         if ({a_gnt, b_gnt} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
            failures++; $display("FAIL tie_gnt c=%0d got=%b exp=%b", c, {a_gnt, b_gnt}, (c % 2 == 0) ? 2'b10 : 2'b01);
         end
         @(posedge clk); #1;
         if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL tie_sb_empty got=0 entries exp=1"); end
         else begin
            r = exp_q.pop_front();
            checks++; if ({a_rvalid, b_rvalid} !== {r.valid & ~r.port, r.valid & r.port}) begin failures++; $display("FAIL tie_rvalid c=%0d got=%b exp=%b", c, {a_rvalid, b_rvalid}, {r.valid & ~r.port, r.valid & r.port}); end
            if (r.valid) begin
               checks++; got = r.port ? {b_err, b_rdata} : {a_err, a_rdata};
               if (got !== {r.err, r.rdata}) begin failures++; $display("FAIL tie_resp c=%0d got err=%b data=%h exp err=%b data=%h", c, got[32], got[31:0], r.err, r.rdata); end
            end
         end
      end
   endtask

   task automatic test_errors();
      logic ga, gb; resp_t r; logic [32:0] got;
      for (int c = 0; c < 2; c++) begin
         drive_idle();
         if (c == 0) drive_a(1'b1, 1'b0, 32'h13, 32'h0, 4'h0);
         else        drive_b(1'b1, 1'b1, 32'h0001_0000, 32'hFFFFFFFF, 4'hF);
         predict(ga, gb);
         #2;
         checks++; if ({a_gnt, b_gnt} !== {ga, gb}) begin failures++; $display("FAIL err_gnt c=%0d got=%b exp=%b", c, {a_gnt, b_gnt}, {ga, gb}); end
         checks++; if ({mem_cs, mem_wren} !== 2'b00) begin failures++; $display("FAIL err_mem c=%0d got cs/wren=%b exp=00", c, {mem_cs, mem_wren}); end
         @(posedge clk); #1;
         if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL err_sb_empty got=0 entries exp=1"); end
         else begin
            r = exp_q.pop_front();
            checks++; if ({a_rvalid, b_rvalid} !== {r.valid & ~r.port, r.valid & r.port}) begin failures++; $display("FAIL err_rvalid c=%0d got=%b exp=%b", c, {a_rvalid, b_rvalid}, {r.valid & ~r.port, r.valid & r.port}); end
            if (r.valid) begin
               checks++; got = r.port ? {b_err, b_rdata} : {a_err, a_rdata};
               if (got !== {r.err, r.rdata}) begin failures++; $display("FAIL err_resp c=%0d got err=%b data=%h exp err=%b data=%h", c, got[32], got[31:0], r.err, r.rdata); end
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic ga, gb; resp_t r; logic [32:0] got;
      for (int c = 0; c < 2; c++) begin
         drive_idle();
         if (c == 0) drive_a(1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF);
         else        drive_a(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
         predict(ga, gb);
         #2;
         checks++; if ({a_gnt, b_gnt} !== {ga, gb}) begin failures++; $display("FAIL b2b_gnt c=%0d got=%b exp=%b", c, {a_gnt, b_gnt}, {ga, gb}); end
         @(posedge clk); #1;
         if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL b2b_sb_empty got=0 entries exp=1"); end
         else begin
            r = exp_q.pop_front();
            checks++; if ({a_rvalid, b_rvalid} !== {r.valid & ~r.port, r.valid & r.port}) begin failures++; $display("FAIL b2b_rvalid c=%0d got=%b exp=%b", c, {a_rvalid, b_rvalid}, {r.valid & ~r.port, r.valid & r.port}); end
            if (r.valid) begin
               checks++; got = r.port ? {b_err, b_rdata} : {a_err, a_rdata};
               if (got !== {r.err, r.rdata}) begin failures++; $display("FAIL b2b_resp c=%0d got err=%b data=%h exp err=%b data=%h", c, got[32], got[31:0], r.err, r.rdata); end
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic ga, gb; resp_t r; logic [32:0] got;
      drive_idle();
      drive_a(1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
      predict(ga, gb);
      #2;
      checks++; if ({a_gnt, b_gnt} !== 2'b10) begin failures++; $display("FAIL mid_gnt got=%b exp=10", {a_gnt, b_gnt}); end
      @(posedge clk); #1;
      reset = 1'b1; last_m = 1'b1;
      drive_b(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
      exp_q.delete();
      #1;
      checks++; if ({a_rvalid, b_rvalid} !== 2'b00) begin failures++; $display("FAIL mid_dropped got=%b exp=00", {a_rvalid, b_rvalid}); end
      checks++; if ({a_gnt, b_gnt, mem_cs, mem_wren} !== 4'b0000) begin failures++; $display("FAIL mid_in_reset got gnt/cs/wren=%b exp=0000", {a_gnt, b_gnt, mem_cs, mem_wren}); end
      @(posedge clk); #1;
      reset = 1'b0;
      predict(ga, gb);
      #2;
      checks++; if ({a_rvalid, b_rvalid} !== 2'b00) begin failures++; $display("FAIL mid_post_rvalid got=%b exp=00", {a_rvalid, b_rvalid}); end
      checks++; if ({a_gnt, b_gnt} !== 2'b10) begin failures++; $display("FAIL mid_tie_gnt got=%b exp=10", {a_gnt, b_gnt}); end
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL mid_sb_empty got=0 entries exp=1"); end
      else begin
         r = exp_q.pop_front();
         checks++; if ({a_rvalid, b_rvalid} !== {r.valid & ~r.port, r.valid & r.port}) begin failures++; $display("FAIL mid_rvalid got=%b exp=%b", {a_rvalid, b_rvalid}, {r.valid & ~r.port, r.valid & r.port}); end
         if (r.valid) begin
            checks++; got = r.port ? {b_err, b_rdata} : {a_err, a_rdata};
            if (got !== {r.err, r.rdata}) begin failures++; $display("FAIL mid_resp got err=%b data=%h exp err=%b data=%h", got[32], got[31:0], r.err, r.rdata); end
         end
      end
      drive_idle();
   endtask

   initial begin
      reset = 1'b1;
      drive_idle();
      last_m = 1'b1;
      test_reset();
      test_single_read();
      test_masked_write();
      test_tie_alternation();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the SPRAM-backed 32-bit data memory. The CPU load/store path (port A) and the UART debug/loader path (port B) share the single memory. The block grants one access per cycle with round-robin fairness, and converts byte addresses and byte enables into SPRAM word addresses and nibble write masks. It routes read data back to the granting port one cycle later and rejects misaligned or out-of-range accesses without touching memory.

## Interface

- ADDR_WIDTH, default 14, word-address bits driven to the SPRAM pair (16K words).
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  port A access request; held with a_we/a_addr/a_wdata/a_be stable until a_gnt.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  32  byte address.
- a_wdata  in  32  write data.
- a_be  in  4  byte enables for writes; bit k enables bits [8k+7:8k].
- a_gnt  out  1  combinational; access accepted this cycle.
- a_rvalid  out  1  registered; response for the access granted in the previous cycle.
- a_rdata  out  32  read data, valid with a_rvalid; 0 for writes and errors.
- a_err  out  1  valid with a_rvalid; 1 = misaligned or out of range.
- b_req, b_we, b_addr, b_wdata, b_be, b_gnt, b_rvalid, b_rdata, b_err: identical to port A, for port B.
- mem_addr  out  ADDR_WIDTH  SPRAM word address.
- mem_wdata  out  32  SPRAM write data ([31:16] to MSW bank, [15:0] to LSW bank).
- mem_maskwren  out  8  nibble mask; [7:4] to MSW bank, [3:0] to LSW bank.
- mem_wren  out  1  SPRAM write enable.
- mem_cs  out  1  SPRAM chip select.
- mem_rdata  in  32  SPRAM read data, valid one cycle after a read with mem_cs high.

## Operation

- Winner selection:
  - Only one port requesting: that port wins.
  - Both requesting: the port not granted most recently wins.
  - `last` pointer updates only on a grant.
  - Reset value of `last` is B, so A wins the first tie.
- Exactly one gnt per cycle at most; the loser's gnt = 0, and it keeps its request asserted.
- Word address = addr[ADDR_WIDTH+1:2].
- Error when either condition holds:
  - misaligned: addr[1:0] != 0;
  - out of range: any bit of addr[31:ADDR_WIDTH+2] set.
- Error access:
  - gnt still asserted;
  - mem_cs = 0 and mem_wren = 0;
  - response carries err = 1 and rdata = 0.
- Valid write: mem_cs = 1, mem_wren = 1, mem_wdata = wdata, mem_maskwren[2k+1:2k] = {2{be[k]}}.
- be = 4'b0000 still performs the cycle with all-zero mask; memory is unchanged.
- Valid read: mem_cs = 1, mem_wren = 0, mem_maskwren = 8'hFF.
- No grant: mem_cs = 0, mem_wren = 0, mem_addr/mem_wdata = 0.
- Response registers:
  - `resp_port` (A/B), `resp_valid`, `resp_read` and `resp_err` are captured at grant.
  - Next cycle, the selected port's rvalid = 1; the other port's rvalid = 0.
  - rdata = mem_rdata when resp_read && !resp_err, else 0.
- Writes also produce rvalid (as a write acknowledge) with rdata = 0.

## Timing

- Grant: combinational from req, same cycle; mem_* outputs are driven the same cycle.
- Response latency: exactly 1 cycle after gnt for reads, writes and errors.
- Throughput: one access per cycle; back-to-back grants are allowed and responses pipeline.
- While both ports request continuously, grants alternate A, B, A, B; the starvation bound is 1 cycle.
- During reset:
  - all gnt = 0, mem_cs = 0, mem_wren = 0;
  - rvalid/err/rdata registers = 0;
  - `last` = B.
- First cycle after reset deassertion: rvalid = 0 on both ports.
- Reset asserted in the cycle after a grant: the pending response is dropped and rvalid stays 0.
- rdata and err are meaningful only while the matching rvalid = 1.

## Test plan

- Single read: preload word 5 = 32'hDEADBEEF; A reads addr 0x14 -> a_gnt same cycle, mem_addr = 5, mem_cs = 1, mem_wren = 0; next cycle a_rvalid = 1, a_rdata = 32'hDEADBEEF, a_err = 0, b_rvalid = 0.
- Byte-masked write: B writes addr 0x20, wdata 32'h11223344, be = 4'b0101 -> mem_maskwren = 8'b00110011, mem_addr = 8; a later read of 0x20 over prior 0 returns 32'h00220044.
- Tie and alternation: after reset, A and B both request for 4 cycles -> grants A, B, A, B; each rvalid follows its grant by 1 cycle on the correct port only.
- Errors: A reads 0x13 (misaligned) and B writes 0x10000 (out of range, ADDR_WIDTH = 14) -> gnt asserted, mem_cs = 0; the responses carry err = 1 and rdata = 0.
- Reset mid-operation: grant an A read, then assert reset the next cycle -> a_rvalid = 0, gnt = 0, mem_cs = 0; after release, a tie grants A first.
- Back-to-back same port: A write 0x40 = 32'hCAFEF00D (be = 4'hF), then A read 0x40 on the next cycle -> read returns 32'hCAFEF00D; rvalid is high for 2 consecutive cycles.
